// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: requester IDs and bus widths shared by the data-memory arbiter, its ID queue and its interface
package dm_arb_pkg;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = 8;
  typedef enum logic {DM_ID_LSP = 1'b0, DM_ID_AUX = 1'b1} dm_id_e;
endpackage

// File: rtl/dm_arb_if.sv
// dm_arb_if: one memory request/response channel (req_addr/wdata/wmask/wen/valid/ready, resp_rdata/valid); master issues requests, slave serves them
interface dm_arb_if;
  import dm_arb_pkg::*;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [MW-1:0] req_wmask;
  logic          req_wen;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_valid;
  modport master (
    output req_addr, req_wdata, req_wmask, req_wen, req_valid,
    input  req_ready, resp_rdata, resp_valid
  );
  modport slave (
    input  req_addr, req_wdata, req_wmask, req_wen, req_valid,
    output req_ready, resp_rdata, resp_valid
  );
endinterface

// File: rtl/dm_arb_idq.sv
// dm_arb_idq: 1-bit synchronous FIFO of requester IDs (clk, rst, push/din in, pop in, dout = head, count/full/empty out); pushes when full and pops when empty are ignored
module dm_arb_idq #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ID_DEPTH_LOG2 = 1,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [MAX_OUTSTANDING-1:0] mem;
  logic [ID_DEPTH_LOG2-1:0] wp, rp;
  logic do_push, do_pop;
  function automatic logic [ID_DEPTH_LOG2-1:0] nxt(input logic [ID_DEPTH_LOG2-1:0] p);
    return p == ID_DEPTH_LOG2'(MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = count == CW'(MAX_OUTSTANDING);
  assign empty = count == '0;
  assign dout = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= nxt(wp);
      end
      if (do_pop) rp <= nxt(rp);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/dm_arb.sv
// dm_arb: round-robin arbiter of requesters r0 (load/store) and r1 (aux) onto one D-mem channel dm; routes in-order responses by ID queue; dm_arb_busy = requests outstanding, dm_arb_err = sticky stray response
module dm_arb
  import dm_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ID_DEPTH_LOG2 = 1
) (
  input  logic     clk,
  input  logic     rst,
  dm_arb_if.slave  r0,
  dm_arb_if.slave  r1,
  dm_arb_if.master dm,
  output logic     dm_arb_busy,
  output logic     dm_arb_err
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  dm_id_e prio, sel;
  logic head, full, empty, accept, pop;
  logic [CW-1:0] count;
  assign sel = (r0.req_valid != r1.req_valid) ? (r1.req_valid ? DM_ID_AUX : DM_ID_LSP) : prio;
  assign dm.req_addr = sel == DM_ID_AUX ? r1.req_addr : r0.req_addr;
  assign dm.req_wdata = sel == DM_ID_AUX ? r1.req_wdata : r0.req_wdata;
  assign dm.req_wmask = sel == DM_ID_AUX ? r1.req_wmask : r0.req_wmask;
  assign dm.req_wen = sel == DM_ID_AUX ? r1.req_wen : r0.req_wen;
  assign dm.req_valid = (sel == DM_ID_AUX ? r1.req_valid : r0.req_valid) && !full && !rst;
  assign r0.req_ready = sel == DM_ID_LSP && dm.req_ready && !full;
  assign r1.req_ready = sel == DM_ID_AUX && dm.req_ready && !full;
  assign accept = dm.req_valid && dm.req_ready;
  assign pop = dm.resp_valid && !empty;
  assign r0.resp_valid = pop && head == DM_ID_LSP;
  assign r1.resp_valid = pop && head == DM_ID_AUX;
  assign r0.resp_rdata = dm.resp_rdata;
  assign r1.resp_rdata = dm.resp_rdata;
  assign dm_arb_busy = count != '0;
  dm_arb_idq #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .ID_DEPTH_LOG2(ID_DEPTH_LOG2)) u_idq (
    .clk(clk), .rst(rst), .push(accept), .pop(pop), .din(sel),
    .dout(head), .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= DM_ID_LSP;
      dm_arb_err <= 1'b0;
    end else begin
      if (accept) prio <= sel == DM_ID_LSP ? DM_ID_AUX : DM_ID_LSP;
      if (dm.resp_valid && empty) dm_arb_err <= 1'b1;
    end
  end
endmodule
